mux_scan: RTL and testbench
===========================

# mux_scan

Parametrised, registered N-to-1 channel multiplexer with valid/ready output handshake and an auto-scan mode. It replaces the fixed 8-to-1 and 16-to-1 behavioural multiplexers wherever several W-bit sources share one downstream consumer. In direct mode it samples a host-selected channel. In scan mode it visits all channels round-robin, with a programmable idle gap between samples.

## Interface
- SELW, default 4: select width. The channel count is N = 2**SELW.
- W, default 8: data width per channel.
- DWW, default 4: width of the dwell (gap) count.
- clk, input, 1: single clock. All state changes on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- en, input, 1: enable sampling.
- mode, input, 1: channel-selection mode. 0 = direct (use sel), 1 = scan (use internal pointer).
- sel, input, SELW: channel number in direct mode.
- dwell, input, DWW: number of idle cycles inserted after each accepted sample.
- w, input, N*W: channel data. Channel c occupies w[c*W +: W].
- f, output, W: sampled data.
- ch, output, SELW: channel number that f came from.
- valid, output, 1: f and ch hold an unaccepted sample.
- ready, input, 1: downstream accepts the sample. A transfer occurs on a cycle where valid && ready.

## Operation
- FSM has three states: IDLE, HOLD, GAP.
- Sample action, taken at a clock edge:
  - Sampled channel c = sel when mode=0, or ptr when mode=1.
  - f <= w[c*W +: W], ch <= c, valid <= 1. Next state is HOLD.
  - mode and sel are read at the sample edge only.
- IDLE: valid=0.
  - en=1: perform the sample action.
  - en=0: stay in IDLE.
- HOLD: valid=1. f and ch stay stable until a transfer.
  - No transfer: stay in HOLD, regardless of en, mode or sel. Samples are never dropped or overwritten.
  - Transfer with en=0: go to IDLE, valid=0.
  - Transfer with en=1 and dwell=0: perform the sample action on the same edge, so valid stays 1 (back-to-back).
  - Transfer with en=1 and dwell>0: go to GAP, load cnt <= dwell, valid=0.
- GAP: valid=0, cnt decrements by 1 each cycle.
  - cnt=1 with en=1: perform the sample action.
  - cnt=1 with en=0: go to IDLE.
  - en deasserted earlier in the gap: the gap still runs to completion, then the FSM goes to IDLE.
- Scan pointer ptr (SELW bits):
  - Increments by 1 on each transfer whose sample was taken with mode=1.
  - Wraps from N-1 to 0 by natural SELW-bit overflow.
  - Unchanged in direct mode.
  - Not reset by mode changes.
- Reset state: state=IDLE, f=0, ch=0, valid=0, ptr=0, cnt=0. Reset asserted mid-HOLD or mid-GAP discards the pending sample immediately, without waiting for a clock.

## Timing
- Latency: valid rises 1 cycle after the edge where en=1 is seen in IDLE.
- f shows w as it was at the sample edge. Later changes on w do not affect f.
- Throughput with dwell=0 and ready=1: one sample per cycle.
- Throughput with dwell=D: one sample per D+1 cycles. Valid is low for exactly D cycles between samples.
- ready is ignored while valid=0.
- There is no combinational path from ready, w or sel to any output. All outputs are registered.

## Test plan
- Reset and direct sample, N=16, W=8:
  - Hold rst_n=0: f=0, ch=0, valid=0.
  - Release; set w channel 5 = 8'hA5, sel=5, mode=0, en=1 for one cycle, ready=0.
  - Required: valid=1 next cycle with f=A5, ch=5, held for 10 cycles.
  - Assert ready: valid=0 the following cycle.
- Backpressure stability:
  - While in HOLD with ready=0, change w channel 5 to 8'h3C and sel to 2.
  - Required: f stays A5 and ch stays 5 until the transfer.
- Scan with wrap:
  - Channel c data = c+8'h10, mode=1, en=1, dwell=0, ready=1.
  - Required: ch sequence 0,1,…,15,0,1 on consecutive cycles.
  - Required: f = 10,11,…,1F,10.
- Dwell gap:
  - Scan mode, dwell=3, ready=1.
  - Required: valid pattern 1,0,0,0,1,0,0,0.
  - Required: ch increments by 1 on each valid=1 cycle.
- en drop and async reset:
  - Deassert en while in HOLD with ready=0. Required: sample held, and after the transfer, IDLE with valid=0.
  - Pulse rst_n low mid-GAP, between clock edges. Required: valid=0 and ptr=0 immediately.
  - Restart scan. Required: ch=0 first.

Source files
------------

// File: rtl/mux_scan_if.sv
// rtl/mux_scan_if.sv - channel, control and output handshake bundle for mux_scan
interface mux_scan_if #(
  parameter int SELW = 4,
  parameter int W    = 8,
  parameter int DWW  = 4
);
  localparam int N = 1 << SELW;

  logic            en;
  logic            mode;
  logic [SELW-1:0] sel;
  logic [DWW-1:0]  dwell;
  logic [N*W-1:0]  w;
  logic [W-1:0]    f;
  logic [SELW-1:0] ch;
  logic            valid;
  logic            ready;

  modport master (
    output en, mode, sel, dwell, w, ready,
    input  f, ch, valid
  );

  modport slave (
    input  en, mode, sel, dwell, w, ready,
    output f, ch, valid
  );
endinterface

// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - registered N-to-1 channel mux with valid/ready output and round-robin scan
module mux_scan #(
  parameter int SELW = 4,
  parameter int W    = 8,
  parameter int DWW  = 4
) (
  input logic       clk,
  input logic       rst_n,
  mux_scan_if.slave bus
);
  localparam int N = 1 << SELW;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t          state_q, state_d;
  logic [DWW-1:0]  cnt_q, cnt_d;
  logic [SELW-1:0] ptr_q, ptr_adv;
  logic [SELW-1:0] chan_sel;
  logic [W-1:0]    f_q;
  logic [SELW-1:0] ch_q;
  logic            valid_q;
  logic            scan_q;
  logic            xfer;
  logic            do_sample;
  logic [W-1:0]    chan [N];
  logic [W-1:0]    w_sel;

  for (genvar g = 0; g < N; g++) begin : g_chan
    assign chan[g] = bus.w[g*W +: W];
  end

  assign xfer = valid_q && bus.ready;

  // The pointer advances on the very edge that may also take the next sample,
  // so a back-to-back scan sample must already see the advanced value.
  assign ptr_adv  = ptr_q + SELW'(xfer && scan_q);
  assign chan_sel = bus.mode ? ptr_adv : bus.sel;
  assign w_sel    = chan[chan_sel];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_sample = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en) do_sample = 1'b1;
      end
      HOLD: begin
        if (bus.ready) begin
          if (!bus.en) begin
            state_d = IDLE;
          end else if (bus.dwell == '0) begin
            do_sample = 1'b1;
          end else begin
            state_d = GAP;
            cnt_d   = bus.dwell;
          end
        end
      end
      GAP: begin
        cnt_d = cnt_q - DWW'(1);
        // en is only consulted on the final gap cycle, so a gap always completes
        if (cnt_q <= DWW'(1)) begin
          cnt_d = '0;
          if (bus.en) do_sample = 1'b1;
          else        state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (do_sample) state_d = HOLD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      f_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      scan_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_adv;
      valid_q <= (state_d == HOLD);
      if (do_sample) begin
        f_q    <= w_sel;
        ch_q   <= chan_sel;
        scan_q <= bus.mode;
      end
    end
  end

  assign bus.f     = f_q;
  assign bus.ch    = ch_q;
  assign bus.valid = valid_q;
endmodule

// File: tb/tb_mux_scan.sv
// tb/tb_mux_scan.sv - directed bench for mux_scan with a transaction-level reference model
module tb_mux_scan;
  localparam int SELW = 4;
  localparam int W    = 8;
  localparam int DWW  = 4;
  localparam int N    = 1 << SELW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mux_scan_if #(.SELW(SELW), .W(W), .DWW(DWW)) bus ();

  mux_scan #(.SELW(SELW), .W(W), .DWW(DWW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [W-1:0] wch [N];
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.w[g*W +: W] = wch[g];
  end

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: an outstanding sample (mv/mf/mch) plus a count of idle cycles left.
  bit       mv = 1'b0;
  int       mf = 0;
  int       mch = 0;
  int       mptr = 0;
  int       mgap = 0;
  bit       mscan = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit smp;
    bit tr;
    int c;
    if (!rst_n) begin
      mv = 0; mf = 0; mch = 0; mptr = 0; mgap = 0; mscan = 0;
    end else begin
      smp = 0;
      tr  = mv && bus.ready;
      if (tr && mscan) mptr = (mptr + 1) % N;
      if (!(mv && !tr)) begin
        if (tr) begin
          mv = 0;
          if (bus.en && bus.dwell == 0) smp = 1;
          else if (bus.en)              mgap = int'(bus.dwell);
        end else if (mgap > 0) begin
          mgap--;
          if (mgap == 0 && bus.en) smp = 1;
        end else if (bus.en) begin
          smp = 1;
        end
        if (smp) begin
          c     = bus.mode ? mptr : int'(bus.sel);
          mf    = int'(wch[c]);
          mch   = c;
          mscan = bus.mode;
          mv    = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && started) begin
      check("model_valid", bus.valid, mv);
      if (mv) begin
        check("model_f", bus.f, mf);
        check("model_ch", bus.ch, mch);
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) wch[i] = '0;
    bus.en = 0; bus.mode = 0; bus.sel = '0; bus.dwell = '0; bus.ready = 0;

    #1 rst_n = 1'b0;
    repeat (3) step();
    check("rst_f", bus.f, 0);
    check("rst_ch", bus.ch, 0);
    check("rst_valid", bus.valid, 0);
    rst_n = 1'b1;
    started = 1'b1;

    // direct sample with backpressure
    wch[5] = 8'hA5; bus.sel = 4'd5; bus.mode = 0; bus.en = 1; bus.ready = 0;
    step();
    bus.en = 0;
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", bus.valid, 1);
      check("hold_f", bus.f, 8'hA5);
      check("hold_ch", bus.ch, 5);
      if (i == 3) begin
        wch[5] = 8'h3C;
        bus.sel = 4'd2;
      end
      step();
    end
    bus.ready = 1;
    step();
    bus.ready = 0;
    check("xfer_idle", bus.valid, 0);

    // scan with wrap
    for (int c = 0; c < N; c++) wch[c] = 8'(c + 8'h10);
    bus.mode = 1; bus.dwell = '0; bus.ready = 1; bus.en = 1;
    step();
    for (int k = 0; k < 18; k++) begin
      check("scan_valid", bus.valid, 1);
      check("scan_ch", bus.ch, k % 16);
      check("scan_f", bus.f, 8'h10 + (k % 16));
      step();
    end
    bus.en = 0;
    step();

    // dwell gap of three
    bus.dwell = 4'd3; bus.en = 1;
    step();
    for (int i = 0; i < 8; i++) begin
      check("dwell_valid", bus.valid, (i % 4 == 0) ? 1 : 0);
      if (i % 4 == 0) check("dwell_ch", bus.ch, 3 + i / 4);
      step();
    end

    // en dropped while held
    bus.ready = 0; bus.en = 0;
    repeat (3) step();
    check("endrop_valid", bus.valid, 1);
    check("endrop_ch", bus.ch, 5);
    bus.ready = 1;
    step();
    bus.ready = 0;
    check("endrop_idle", bus.valid, 0);
    repeat (2) step();
    check("endrop_stay", bus.valid, 0);

    // asynchronous reset in the middle of a gap
    bus.en = 1; bus.dwell = 4'd5; bus.ready = 1;
    step();
    check("gap_pre_ch", bus.ch, 6);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", bus.valid, 0);
    check("async_ch", bus.ch, 0);
    rst_n = 1'b1;
    n = 0;
    step();
    while (!bus.valid && n < 10) begin
      step();
      n++;
    end
    check("restart_timeout", (n < 10) ? 1 : 0, 1);
    check("restart_ch", bus.ch, 0);
    check("restart_f", bus.f, 8'h10);

    bus.en = 0;
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
